// File: rtl/sgpr_wb_arbiter_if.sv
// Bus bundle between the write-back arbiter and its neighbours:
// ALU result port, LSU load return, decode hazard lookup and register file write port.
interface sgpr_wb_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    // ALU result (single cycle, stall-only back-pressure)
    logic                  alu_we_i;
    logic [ADDR_W-1:0]     alu_waddr_i;
    logic [DATA_WIDTH-1:0] alu_wdata_i;
    logic                  alu_stall_o;

    // LSU load return (valid/ready)
    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [ADDR_W-1:0]     lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;

    // Decode hazard lookup
    logic [ADDR_W-1:0]     raddr_a_i;
    logic [ADDR_W-1:0]     raddr_b_i;
    logic                  hazard_a_o;
    logic                  hazard_b_o;

    // Status and register file write port
    logic [CNT_W-1:0]      fifo_count_o;
    logic                  we_a_o;
    logic [ADDR_W-1:0]     waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;

    // Arbiter side
    modport slave (
        input  alu_we_i, alu_waddr_i, alu_wdata_i,
        output alu_stall_o,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_ready_o,
        input  raddr_a_i, raddr_b_i,
        output hazard_a_o, hazard_b_o,
        output fifo_count_o,
        output we_a_o, waddr_a_o, wdata_a_o
    );

    // Producer / consumer side
    modport master (
        output alu_we_i, alu_waddr_i, alu_wdata_i,
        input  alu_stall_o,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_ready_o,
        output raddr_a_i, raddr_b_i,
        input  hazard_a_o, hazard_b_o,
        input  fifo_count_o,
        input  we_a_o, waddr_a_o, wdata_a_o
    );
endinterface

// File: rtl/sgpr_wb_arbiter.sv
// SGPR write-back arbiter: merges ALU results and buffered LSU loads into the
// single register file write port, with starvation guard and RAW hazard flags.
// The interface must be instantiated with the same DATA_WIDTH/FIFO_DEPTH.
module sgpr_wb_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    sgpr_wb_arbiter_if.slave   bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);

    // Load buffer storage; validity is tracked separately so reset can drop
    // entries without clearing the data arrays.
    logic [ADDR_W-1:0]     ent_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_vld, ent_vld_n;

    logic [PTR_W-1:0]      head, head_n;
    logic [PTR_W-1:0]      tail, tail_n;
    logic [CNT_W-1:0]      count, count_n;
    logic [STV_W-1:0]      starve, starve_n;

    logic                  we_q, we_n;
    logic [ADDR_W-1:0]     waddr_q, waddr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;

    logic                  ready_c;
    logic                  stall_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  alu_win_c;
    logic                  fifo_nonempty_c;
    logic                  hit_a_c, hit_b_c;

    // Handshake and arbitration decisions, all from registered state plus inputs
    always_comb begin
        fifo_nonempty_c = (count != '0);
        ready_c   = !rst && (count < CNT_W'(FIFO_DEPTH));
        stall_c   = !rst && (starve == STV_W'(STARVE_LIMIT)) && fifo_nonempty_c;
        push_c    = bus.lsu_valid_i && ready_c && (bus.lsu_waddr_i != '0);
        alu_win_c = bus.alu_we_i && (bus.alu_waddr_i != '0) && !stall_c;
        pop_c     = stall_c || (!alu_win_c && fifo_nonempty_c);
    end

    // Next-state: FIFO pointers/occupancy, starvation counter, output stage
    always_comb begin
        head_n    = head;
        tail_n    = tail;
        count_n   = count;
        ent_vld_n = ent_vld;
        starve_n  = starve;
        we_n      = 1'b0;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;

        if (pop_c) begin
            ent_vld_n[head] = 1'b0;
            head_n          = head + PTR_W'(1);
            we_n            = 1'b1;
            waddr_n         = ent_addr[head];
            wdata_n         = ent_data[head];
        end else if (alu_win_c) begin
            we_n            = 1'b1;
            waddr_n         = bus.alu_waddr_i;
            wdata_n         = bus.alu_wdata_i;
        end

        if (push_c) begin
            ent_vld_n[tail] = 1'b1;
            tail_n          = tail + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase

        if (pop_c || !fifo_nonempty_c) begin
            starve_n = '0;
        end else if (alu_win_c && (starve != STV_W'(STARVE_LIMIT))) begin
            starve_n = starve + STV_W'(1);
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
            starve  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            head    <= head_n;
            tail    <= tail_n;
            count   <= count_n;
            ent_vld <= ent_vld_n;
            starve  <= starve_n;
            we_q    <= we_n;
            waddr_q <= waddr_n;
            wdata_q <= wdata_n;
        end
    end

    // Load buffer payload write at the tail
    always_ff @(posedge clk) begin
        if (push_c) begin
            ent_addr[tail] <= bus.lsu_waddr_i;
            ent_data[tail] <= bus.lsu_wdata_i;
        end
    end

    // RAW lookup against buffered loads and the write currently at the register file
    always_comb begin
        hit_a_c = we_q && (waddr_q == bus.raddr_a_i);
        hit_b_c = we_q && (waddr_q == bus.raddr_b_i);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == bus.raddr_a_i)) hit_a_c = 1'b1;
            if (ent_vld[i] && (ent_addr[i] == bus.raddr_b_i)) hit_b_c = 1'b1;
        end
    end

    assign bus.lsu_ready_o  = ready_c;
    assign bus.alu_stall_o  = stall_c;
    assign bus.hazard_a_o   = !rst && (bus.raddr_a_i != '0) && hit_a_c;
    assign bus.hazard_b_o   = !rst && (bus.raddr_b_i != '0) && hit_b_c;
    assign bus.fifo_count_o = count;
    assign bus.we_a_o       = we_q;
    assign bus.waddr_a_o    = waddr_q;
    assign bus.wdata_a_o    = wdata_q;

endmodule

// File: doc/sgpr_wb_arbiter.md
# sgpr_wb_arbiter

Write-back arbiter and load buffer sitting directly upstream of the SGPR register file write port. It merges single-cycle ALU results and handshaked LSU load returns into the register file's single write port (we/waddr/wdata) through a registered output stage. Pending loads are held in a small FIFO, and a starvation counter guarantees load forward progress. It also flags read-after-write hazards for decode against writes not yet visible in the register file.

## Interface
- DATA_WIDTH, 32, data width; matches the register file.
- FIFO_DEPTH, 2, LSU buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive ALU wins over a non-empty FIFO before the LSU is forced through.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alu_we_i  in  1  ALU write request (single cycle, no ready)
- alu_waddr_i  in  5  ALU destination register
- alu_wdata_i  in  DATA_WIDTH  ALU result
- alu_stall_o  out  1  ALU write this cycle is ignored; producer must hold it and re-present it
- lsu_valid_i  in  1  load data valid
- lsu_ready_o  out  1  FIFO can accept
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  DATA_WIDTH  load data
- raddr_a_i, raddr_b_i  in  5  decode read addresses
- hazard_a_o, hazard_b_o  out  1  read address has a pending write
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupied entries
- we_a_o  out  1  to register file we_a_i
- waddr_a_o  out  5  to register file waddr_a_i
- wdata_a_o  out  DATA_WIDTH  to register file wdata_a_i

## Operation
- Reset (rst=1 at clk edge): count=0, starve_cnt=0, we_a_o=0, waddr_a_o=0, wdata_a_o=0. While rst is high, lsu_ready_o=0, alu_stall_o=0, hazards=0, and FIFO contents are discarded.
- lsu_ready_o = (count < FIFO_DEPTH). It depends only on registered state, never on lsu_valid_i. There is no pass-through when full: a pop in the same cycle does not raise ready.
- Handshake: lsu_valid_i & lsu_ready_o. The entry is enqueued at the tail. If lsu_waddr_i==0, the handshake completes but nothing is enqueued.
- ALU request is effective when alu_we_i=1, alu_waddr_i≠0 and alu_stall_o=0. Writes to x0 are dropped silently.
- alu_stall_o = (starve_cnt == STARVE_LIMIT) & (count≠0). This is combinational from registered state.
- Grant, evaluated each cycle:
  - If alu_stall_o=1, pop the FIFO head.
  - Else if the ALU request is effective, the ALU wins.
  - Else if count≠0, pop the FIFO head.
  - Else no grant.
- starve_cnt:
  - Cleared on any FIFO pop, or whenever count==0.
  - Otherwise incremented when the ALU wins with count≠0, saturating at STARVE_LIMIT.
- Output register:
  - On grant: we_a_o←1, and waddr/wdata←the winner's values.
  - With no grant: we_a_o←0, and waddr/wdata hold their previous values.
- Simultaneous push and pop: count is unchanged and entries keep FIFO order. LSU entries are never reordered among themselves.
- Hazard: hazard_x_o = (raddr_x_i≠0) & (match against any valid FIFO entry address, or against we_a_o & waddr_a_o). This is combinational. An ALU write in the current cycle is not included; decode handles it by its own bypass.
- Ordering between the ALU and the LSU to the same register is not arbitrated. Decode must not issue an ALU write to a register whose hazard flag is set.

## Timing
- ALU write presented in cycle N → we_a_o=1 in cycle N+1 → register file updated at the end of cycle N+1 (readable in N+2).
- LSU handshake in cycle N → entry visible in cycle N+1 → earliest we_a_o in cycle N+2.
- fifo_count_o and lsu_ready_o update one cycle after the push or pop.
- Worst case, the FIFO head waits STARVE_LIMIT ALU wins and is then written in the following cycle. Maximum gap for the head is STARVE_LIMIT+1 grant cycles.
- alu_stall_o lasts exactly one cycle per forced pop, because starve_cnt clears on that pop.
- Hazard flags assert in the handshake's following cycle and stay asserted through the cycle in which we_a_o=1 for that entry.
- Reset mid-operation: all pending FIFO entries are lost and never written. we_a_o is 0 in the cycle after the reset edge.

## Test plan
- ALU path: after reset, alu_we_i=1, waddr=5, wdata=0xDEADBEEF in cycle 1 → we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF in cycle 2 only. In cycle 3, we_a_o=0 and data is held.
- LSU path: push x7=0x12345678 in cycle 1 with no ALU activity:
  - fifo_count_o=1 in cycle 2.
  - we_a_o with x7/0x12345678 in cycle 3.
  - hazard_a_o=1 for raddr_a_i=7 in cycles 2–3, and 0 in cycle 4.
- Starvation: push x1 then x2 while the ALU writes x10 every cycle:
  - lsu_ready_o=0 at count 2.
  - After 4 ALU wins, alu_stall_o=1 for one cycle and x1 is written next.
  - After 4 further ALU wins, x2 is written.
  - ALU data is never lost if re-presented.
- x0 filtering: ALU write to x0 → no we_a_o. LSU push to x0 → handshake completes, count stays 0. raddr_a_i=0 → hazard_a_o=0.
- Full FIFO: with count=2 and a pop plus lsu_valid_i in the same cycle → no push (ready=0). Next cycle count=1, ready=1, and the push is accepted.
- Reset mid-operation: rst=1 for one cycle with count=2 → count=0, we_a_o=0, no write of pending entries afterwards, lsu_ready_o=1 after rst drops.
